// File: rtl/cpu_icache_pkg.sv
// Shared types and derived widths for the lined instruction cache.
package cpu_icache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    FILL,
    BYPASS,
    INITIALIZE
  } state_t;

  // Tag bits left once the word, line offset and index bits are removed.
  function automatic int tag_w(input int size, input int line_log2);
    return 30 - size - line_log2;
  endfunction

  function automatic int data_aw(input int size, input int line_log2);
    return size + line_log2;
  endfunction

endpackage

// File: rtl/cpu_icache_bram.sv
// Simple dual-port block RAM: one write port, one registered read port.
module cpu_icache_bram #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // NOTE: the array has no reset; the cache's tag sweep is what makes contents meaningful.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/cpu_icache_lined.sv
// Direct-mapped instruction cache with multi-word lines, filled one bus word at a time.
module cpu_icache_lined
  import cpu_icache_pkg::*;
#(
  parameter int          SIZE          = 8,
  parameter int          LINE_LOG2     = 2,
  parameter logic [31:0] UNCACHED_BASE = 32'h8000_0000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [31:0] i_input_pc,
  input  logic        i_stall,
  input  logic        i_flush,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_busy,
  output logic        o_bus_request,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_address,
  input  logic [31:0] i_bus_rdata,
  output logic [31:0] o_hit_count,
  output logic [31:0] o_miss_count
);

  localparam int TAG_W  = tag_w(SIZE, LINE_LOG2);
  localparam int DAW    = data_aw(SIZE, LINE_LOG2);
  localparam int TAG_LO = SIZE + LINE_LOG2 + 2;

  state_t               state, next_state;
  logic [SIZE-1:0]      clear_idx;
  logic [LINE_LOG2-1:0] fill_count;
  logic                 flush_pending;
  logic [31:0]          lookup_pc, next_lookup_pc;
  logic [31:0]          hit_count, miss_count;
  logic [31:0]          pc_next;

  logic                 tag_we, data_we;
  logic [SIZE-1:0]      tag_waddr;
  logic [TAG_W:0]       tag_wdata, tag_rdata;
  logic [DAW-1:0]       rd_word, data_waddr;
  logic [31:0]          data_rdata;

  logic ready, use_bus, bus_req, hit_inc, miss_inc, hit, pending;
  logic [31:0] bus_addr;

  assign pc_next    = i_input_pc + 32'd4;
  assign data_waddr = {lookup_pc[TAG_LO-1:LINE_LOG2+2], fill_count};
  assign pending    = flush_pending | i_flush;
  assign hit        = (lookup_pc == i_input_pc) && tag_rdata[TAG_W] &&
                      (tag_rdata[TAG_W-1:0] == lookup_pc[31:TAG_LO]);

  cpu_icache_bram #(.AW(SIZE), .DW(TAG_W + 1)) u_tag_ram (
    .clk   (i_clock),
    .we    (tag_we),
    .waddr (tag_waddr),
    .wdata (tag_wdata),
    .raddr (rd_word[DAW-1:LINE_LOG2]),
    .rdata (tag_rdata)
  );

  cpu_icache_bram #(.AW(DAW), .DW(32)) u_data_ram (
    .clk   (i_clock),
    .we    (data_we),
    .waddr (data_waddr),
    .wdata (i_bus_rdata),
    .raddr (rd_word),
    .rdata (data_rdata)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    next_state     = state;
    next_lookup_pc = lookup_pc;
    rd_word        = i_input_pc[TAG_LO-1:2];
    tag_we         = 1'b0;
    tag_waddr      = lookup_pc[TAG_LO-1:LINE_LOG2+2];
    tag_wdata      = {1'b1, lookup_pc[31:TAG_LO]};
    data_we        = 1'b0;
    ready          = 1'b0;
    use_bus        = 1'b0;
    bus_req        = 1'b0;
    bus_addr       = {lookup_pc[31:LINE_LOG2+2], fill_count, 2'b00};
    hit_inc        = 1'b0;
    miss_inc       = 1'b0;

    case (state)
      INITIALIZE: begin
        tag_we    = 1'b1;
        tag_waddr = clear_idx;
        tag_wdata = '0;
        if (&clear_idx) next_state = IDLE;
      end
      IDLE: begin
        if (i_flush) next_state = INITIALIZE;
        else if (!i_stall) begin
          if (i_input_pc >= UNCACHED_BASE) next_state = BYPASS;
          else begin
            next_lookup_pc = i_input_pc;
            next_state     = LOOKUP;
          end
        end
      end
      LOOKUP: begin
        if (i_flush) next_state = INITIALIZE;
        else if (i_stall) next_state = IDLE;
        // A jump into the uncached window is routed through IDLE so it never allocates.
        else if (i_input_pc >= UNCACHED_BASE) next_state = IDLE;
        else if (hit) begin
          ready          = 1'b1;
          hit_inc        = 1'b1;
          rd_word        = pc_next[TAG_LO-1:2];
          next_lookup_pc = pc_next;
        end else if (lookup_pc != i_input_pc) begin
          next_lookup_pc = i_input_pc;
        end else begin
          miss_inc   = 1'b1;
          next_state = FILL;
        end
      end
      FILL: begin
        bus_req = 1'b1;
        if (i_bus_ready) begin
          data_we = 1'b1;
          if (&fill_count) begin
            tag_we     = 1'b1;
            next_state = pending ? INITIALIZE : IDLE;
          end
        end
      end
      BYPASS: begin
        bus_req  = 1'b1;
        bus_addr = i_input_pc;
        if (i_bus_ready) begin
          ready      = 1'b1;
          use_bus    = 1'b1;
          next_state = pending ? INITIALIZE : IDLE;
        end
      end
      default: next_state = INITIALIZE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= INITIALIZE;
      clear_idx     <= '0;
      fill_count    <= '0;
      flush_pending <= 1'b0;
      lookup_pc     <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
    end else begin
      state     <= next_state;
      lookup_pc <= next_lookup_pc;
      clear_idx <= (state == INITIALIZE) ? clear_idx + 1'b1 : '0;
      if (state != FILL) fill_count <= '0;
      else if (i_bus_ready) fill_count <= fill_count + 1'b1;
      // A flush arriving mid-transfer is remembered and honoured when the transfer ends.
      if ((state == FILL || state == BYPASS) && next_state != INITIALIZE)
        flush_pending <= pending;
      else
        flush_pending <= 1'b0;
      if (hit_inc)  hit_count  <= hit_count + 32'd1;
      if (miss_inc) miss_count <= miss_count + 32'd1;
    end
  end

  assign o_ready       = ready & ~i_reset;
  assign o_bus_request = bus_req & ~i_reset;
  assign o_bus_address = bus_addr;
  assign o_rdata       = o_ready ? (use_bus ? i_bus_rdata : data_rdata) : 32'd0;
  assign o_busy        = (state == INITIALIZE);
  assign o_hit_count   = hit_count;
  assign o_miss_count  = miss_count;

endmodule

// File: tb/tb_cpu_icache_lined.sv
// Self-checking bench for cpu_icache_lined: vector table, bus responder and read-data scoreboard.
module tb_cpu_icache_lined;

  logic        clk = 1'b0;
  logic        reset, stall, flush, bus_ready;
  logic [31:0] pc, bus_rdata;
  logic [31:0] rdata, bus_address, hit_count, miss_count;
  logic        ready, busy, bus_request;

  int checks = 0;
  int fails  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] bus_log[$];

  always #5 clk = ~clk;

  cpu_icache_lined dut (
    .i_clock       (clk),
    .i_reset       (reset),
    .i_input_pc    (pc),
    .i_stall       (stall),
    .i_flush       (flush),
    .o_rdata       (rdata),
    .o_ready       (ready),
    .o_busy        (busy),
    .o_bus_request (bus_request),
    .i_bus_ready   (bus_ready),
    .o_bus_address (bus_address),
    .i_bus_rdata   (bus_rdata),
    .o_hit_count   (hit_count),
    .o_miss_count  (miss_count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every o_ready pops the word expected for the fetch in flight.
  always @(negedge clk) begin
    if (ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_ready: got data %h with nothing outstanding", rdata);
      end else begin
        check("rdata", rdata, exp_q.pop_front());
      end
    end
  end

  // Bus slave: answers each request after two cycles, one-cycle ready strobe.
  initial begin
    int wait_cnt = 0;
    bus_ready = 1'b0;
    bus_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (bus_ready) bus_ready = 1'b0;
      else if (bus_request) begin
        wait_cnt++;
        if (wait_cnt >= 2) begin
          bus_ready = 1'b1;
          bus_rdata = mem_word(bus_address);
          bus_log.push_back(bus_address);
          wait_cnt  = 0;
        end
      end else wait_cnt = 0;
    end
  end

  task automatic fetch(input logic [31:0] a, output int cycles, output logic ok);
    pc = a;
    exp_q.push_back(mem_word(a));
    cycles = 0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      cycles++;
      if (ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] pc;
    int          exp_cycles;   // 0 = latency not checked
    int          exp_reads;
    logic [31:0] bus_base;
    logic [31:0] exp_hits;
    logic [31:0] exp_misses;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int   cycles, busy_cnt, bad_cnt, reads_at_busy;
    logic ok, flushed;

    vecs[0] = '{32'h0000_0100, 0, 4, 32'h0000_0100, 1, 1};  // cold miss, refetch hits
    vecs[1] = '{32'h0000_0104, 1, 0, 32'h0,         2, 1};
    vecs[2] = '{32'h0000_0108, 1, 0, 32'h0,         3, 1};
    vecs[3] = '{32'h0000_010C, 1, 0, 32'h0,         4, 1};
    vecs[4] = '{32'h0000_1100, 0, 4, 32'h0000_1100, 5, 2};  // same index, new tag
    vecs[5] = '{32'h0000_0100, 0, 4, 32'h0000_0100, 6, 3};  // evicted, refills
    vecs[6] = '{32'h0000_0104, 1, 0, 32'h0,         7, 3};
    vecs[7] = '{32'h0000_010C, 2, 0, 32'h0,         8, 3};  // redirect: one bubble
    vecs[8] = '{32'h8000_0010, 0, 1, 32'h8000_0010, 8, 3};  // uncached window
    vecs[9] = '{32'h8000_0010, 0, 1, 32'h8000_0010, 8, 3};

    reset = 1'b1;
    stall = 1'b1;
    flush = 1'b0;
    pc    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready",       {31'd0, ready},       32'd0);
    check("reset_bus_request", {31'd0, bus_request}, 32'd0);
    check("reset_rdata",       rdata,                32'd0);
    check("reset_hit_count",   hit_count,            32'd0);
    check("reset_miss_count",  miss_count,           32'd0);

    @(posedge clk);
    #1 reset = 1'b0;
    busy_cnt = 0;
    bad_cnt  = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (ready || bus_request) bad_cnt++;
      if (!busy) break;
      busy_cnt++;
    end
    check("init_busy_cycles", busy_cnt, 256);
    check("init_quiet",       bad_cnt,  0);

    @(posedge clk);
    #1 stall = 1'b0;
    foreach (vecs[k]) begin
      bus_log.delete();
      fetch(vecs[k].pc, cycles, ok);
      check($sformatf("v%0d_ready_seen", k), {31'd0, ok}, 32'd1);
      if (vecs[k].exp_cycles != 0)
        check($sformatf("v%0d_latency", k), cycles, vecs[k].exp_cycles);
      check($sformatf("v%0d_bus_reads", k), bus_log.size(), vecs[k].exp_reads);
      for (int i = 0; i < bus_log.size() && i < vecs[k].exp_reads; i++)
        check($sformatf("v%0d_bus_addr%0d", k, i), bus_log[i], vecs[k].bus_base + 32'(4 * i));
      check($sformatf("v%0d_hits", k),   hit_count,  vecs[k].exp_hits);
      check($sformatf("v%0d_misses", k), miss_count, vecs[k].exp_misses);
    end
    stall = 1'b1;
    repeat (2) @(posedge clk);

    // Flush pulsed during the fill of 0x200: line completes, sweep runs, refetch misses again.
    #1;
    bus_log.delete();
    stall = 1'b0;
    pc = 32'h0000_0200;
    exp_q.push_back(mem_word(pc));
    flushed = 1'b0;
    ok = 1'b0;
    busy_cnt = 0;
    reads_at_busy = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (busy) begin
        busy_cnt++;
        if (reads_at_busy < 0) reads_at_busy = bus_log.size();
      end
      if (!flushed && bus_log.size() >= 1) begin
        flush = 1'b1;
        flushed = 1'b1;
      end else flush = 1'b0;
      if (ready) begin
        ok = 1'b1;
        break;
      end
    end
    flush = 1'b0;
    @(posedge clk);
    #1 stall = 1'b1;
    check("flush_ready_seen",    {31'd0, ok}, 32'd1);
    check("flush_reads_at_busy", reads_at_busy, 4);
    check("flush_sweep_cycles",  busy_cnt, 256);
    check("flush_bus_reads",     bus_log.size(), 8);
    for (int i = 0; i < bus_log.size() && i < 8; i++)
      check($sformatf("flush_bus_addr%0d", i), bus_log[i], 32'h0000_0200 + 32'(4 * (i % 4)));
    check("flush_misses", miss_count, 32'd5);
    check("flush_hits",   hit_count,  32'd9);
    repeat (2) @(posedge clk);

    // Reset in the middle of a fill: request drops at once, sweep reruns, line refills.
    #1;
    bus_log.delete();
    stall = 1'b0;
    pc = 32'h0000_0300;
    exp_q.push_back(mem_word(pc));
    for (int i = 0; i < 200 && bus_log.size() < 2; i++) @(negedge clk);
    check("rst_mid_fill_reached", bus_log.size(), 2);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_bus_request_drop", {31'd0, bus_request}, 32'd0);
    check("rst_ready_low",        {31'd0, ready},       32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    bus_log.delete();
    busy_cnt = 0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1 stall = 1'b1;
    check("rst_ready_seen",   {31'd0, ok}, 32'd1);
    check("rst_sweep_cycles", busy_cnt, 256);
    check("rst_bus_reads",    bus_log.size(), 4);
    for (int i = 0; i < bus_log.size() && i < 4; i++)
      check($sformatf("rst_bus_addr%0d", i), bus_log[i], 32'h0000_0300 + 32'(4 * i));
    check("rst_misses", miss_count, 32'd1);
    check("rst_hits",   hit_count,  32'd1);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
